bp_dma_desc_scheduler: RTL
==========================

# bp_dma_desc_scheduler

Descriptor scheduler for the DMA engine's CSR port. It accepts copy descriptors (source, destination, length) from up to `num_req_p` requesters and grants them round-robin. For each granted descriptor it programs the DMA controller's register file and polls its status until the transfer finishes, then returns a completion with the requester ID and an error flag. It sits between the on-tile clients (accelerator, NIC, boot loader) and the DMA engine's device interface, so only one transfer is in flight at a time.

## Interface
- `num_req_p`, 2: number of requesters (≥1).
- `addr_width_p`, 40: physical address width (paddr).
- `len_width_p`, 16: transfer length field width, in bytes.
- `csr_addr_width_p`, 20: DMA CSR address width (dev_addr_width).
- `csr_base_p`, 0: base address of the DMA CSR block.
- `poll_gap_p`, 4: idle cycles between status polls (≥1).
- `max_polls_p`, 1024: poll count before timeout.

Ports:
- `clk_i`  in  1  clock.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `req_v_i`  in  num_req_p  per-requester descriptor valid.
- `req_src_i`  in  num_req_p*addr_width_p  source addresses; requester i occupies slice i.
- `req_dst_i`  in  num_req_p*addr_width_p  destination addresses.
- `req_len_i`  in  num_req_p*len_width_p  byte lengths.
- `req_ready_and_o`  out  num_req_p  one-hot accept.
- `done_v_o`  out  1  completion valid.
- `done_id_o`  out  clog2(num_req_p)  completed requester.
- `done_err_o`  out  1  bad length, DMA error, or timeout.
- `done_ready_and_i`  in  1  completion consumed.
- `csr_addr_o`  out  csr_addr_width_p  CSR address.
- `csr_data_o`  out  64  CSR write data.
- `csr_w_o`  out  1  1 = write, 0 = read.
- `csr_v_o`  out  1  CSR request valid.
- `csr_yumi_i`  in  1  CSR request taken.
- `csr_data_i`  in  64  CSR read data.
- `csr_v_i`  in  1  read data valid.
- `busy_o`  out  1  state ≠ IDLE.

## Operation
- CSR map, offsets from `csr_base_p`:
  - 0x00: SRC.
  - 0x08: DST.
  - 0x10: LEN, in bytes.
  - 0x18: CTRL, write 1 to start.
  - 0x20: STATUS, bit0 = busy, bit1 = error.
- Address values are zero-extended to 64 bits.
- States: IDLE, WR_SRC, WR_DST, WR_LEN, WR_CTRL, RD_STAT, WAIT_STAT, GAP, DONE.
- IDLE arbitration:
  - Round-robin over `req_v_i`, starting at pointer `rr`.
  - The winner's `req_ready_and_o` bit is high in the same cycle, combinationally.
  - On accept, latch src, dst, len and id, and set `rr` to id+1 mod num_req_p.
  - No requester is ever ready outside IDLE.
- Length check, done on the accepted descriptor:
  - len==0 → DONE with err=0 and no CSR traffic.
  - len[3:0]≠0 (not a 128b multiple) → DONE with err=1 and no CSR traffic.
  - Otherwise → WR_SRC.
- WR_SRC → WR_DST → WR_LEN → WR_CTRL:
  - Each state holds `csr_v_o`=1, `csr_w_o`=1, and stable address/data until `csr_yumi_i`, then advances.
  - Writes have no response.
- After WR_CTRL: clear the poll counter and go to RD_STAT.
- RD_STAT: `csr_v_o`=1, `csr_w_o`=0, addr = base+0x20; on `csr_yumi_i` → WAIT_STAT.
- WAIT_STAT:
  - Wait for `csr_v_i`, then increment the poll counter.
  - bit1 set → DONE, err=1.
  - bit0 clear → DONE, err=0.
  - bit0 set and counter == max_polls_p → DONE, err=1.
  - Otherwise → GAP.
- GAP: count `poll_gap_p` cycles, then → RD_STAT.
- DONE: `done_v_o`=1 with id/err stable until `done_ready_and_i`; then → IDLE.
- `csr_v_i` outside WAIT_STAT is ignored.
- `csr_yumi_i` while `csr_v_o`=0 is ignored.

## Timing
- Reset values:
  - All outputs 0; `csr_addr_o` and `csr_data_o` 0.
  - State IDLE; `rr`=0; counters 0.
- Reset mid-operation: asynchronous return to IDLE. An in-flight CSR request is dropped and no completion is produced.
- Accept in cycle T → `csr_v_o` high at T+1.
- With `csr_yumi_i` tied high: SRC/DST/LEN/CTRL writes occupy T+1..T+4, and the status read request is at T+5.
- Status read is at T+5 → `csr_v_i` at cycle S with busy=0 → `done_v_o` at S+1.
- Busy status at S → the next read request is at S+1+poll_gap_p.
- Bad or zero length accepted at T → `done_v_o` at T+1.
- DONE handshake at cycle D → IDLE at D+1. The earliest next accept is D+1, so there are no back-to-back accepts through DONE.
- Poll counter width is clog2(max_polls_p+1) and it saturates.

## Test plan
- Single request: requester 0, src=0x8000_0000, dst=0x8010_0000, len=64; status busy twice then 0. Expect:
  - Writes 0x8000_0000, 0x8010_0000, 64, 1 to offsets 0x00/0x08/0x10/0x18 in order.
  - Three STATUS reads, each 4 gap cycles apart.
  - done id=0, err=0.
- Fairness: both requesters hold valid continuously for 4 transfers → grants alternate 0,1,0,1 starting from 0 after reset.
- Length errors: len=0 → done err=0 with zero CSR requests; len=40 → done err=1 with zero CSR requests. Both complete one cycle after accept.
- Backpressure: `csr_yumi_i` low for 3 cycles on each request → addr/data held stable, no state skipped. `done_ready_and_i` low for 5 cycles → `done_v_o`, id and err stable.
- Errors: STATUS=0x2 → done err=1. With max_polls_p=3 and STATUS always 0x1 → exactly 3 reads, then done err=1.
- Reset mid-transfer: assert `reset_n_i` low in WAIT_STAT → all outputs 0 immediately; after release, a late `csr_v_i` is ignored and the next request is served normally.

Source files
------------

// File: rtl/bp_dma_desc_scheduler.sv
// Round-robin DMA descriptor scheduler: programs the DMA CSR block for one
// granted copy at a time, polls STATUS and returns a completion per descriptor.
module bp_dma_desc_scheduler #(
  parameter int num_req_p = 2,
  parameter int addr_width_p = 40,
  parameter int len_width_p = 16,
  parameter int csr_addr_width_p = 20,
  parameter logic [csr_addr_width_p-1:0] csr_base_p = '0,
  parameter int poll_gap_p = 4,
  parameter int max_polls_p = 1024,
  localparam int id_w_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic [num_req_p-1:0] req_v_i,
  input  logic [num_req_p*addr_width_p-1:0] req_src_i,
  input  logic [num_req_p*addr_width_p-1:0] req_dst_i,
  input  logic [num_req_p*len_width_p-1:0] req_len_i,
  output logic [num_req_p-1:0] req_ready_and_o,
  output logic done_v_o,
  output logic [id_w_lp-1:0] done_id_o,
  output logic done_err_o,
  input  logic done_ready_and_i,
  output logic [csr_addr_width_p-1:0] csr_addr_o,
  output logic [63:0] csr_data_o,
  output logic csr_w_o,
  output logic csr_v_o,
  input  logic csr_yumi_i,
  input  logic [63:0] csr_data_i,
  input  logic csr_v_i,
  output logic busy_o
);

  localparam int pc_w_lp = $clog2(max_polls_p + 1);
  localparam int gc_w_lp = $clog2(poll_gap_p + 1);

  typedef logic [id_w_lp-1:0] id_t;
  typedef logic [csr_addr_width_p-1:0] caddr_t;
  typedef logic [pc_w_lp-1:0] pcnt_t;
  typedef logic [gc_w_lp-1:0] gcnt_t;

  localparam logic [3:0] idle_s = 4'd0;
  localparam logic [3:0] wr_src_s = 4'd1;
  localparam logic [3:0] wr_dst_s = 4'd2;
  localparam logic [3:0] wr_len_s = 4'd3;
  localparam logic [3:0] wr_ctrl_s = 4'd4;
  localparam logic [3:0] rd_stat_s = 4'd5;
  localparam logic [3:0] wait_stat_s = 4'd6;
  localparam logic [3:0] gap_s = 4'd7;
  localparam logic [3:0] done_s = 4'd8;

  localparam caddr_t off_src_lp = caddr_t'(8'h00);
  localparam caddr_t off_dst_lp = caddr_t'(8'h08);
  localparam caddr_t off_len_lp = caddr_t'(8'h10);
  localparam caddr_t off_ctrl_lp = caddr_t'(8'h18);
  localparam caddr_t off_stat_lp = caddr_t'(8'h20);

  localparam logic [id_w_lp:0] n_lp = (id_w_lp + 1)'(num_req_p);
  localparam id_t last_id_lp = id_t'(num_req_p - 1);
  localparam pcnt_t max_polls_lp = pcnt_t'(max_polls_p);
  localparam gcnt_t gap_last_lp = gcnt_t'(poll_gap_p - 1);

  logic [3:0] state_r;
  id_t rr_r;
  id_t id_r;
  logic err_r;
  logic [addr_width_p-1:0] src_r;
  logic [addr_width_p-1:0] dst_r;
  logic [len_width_p-1:0] len_r;
  pcnt_t poll_r;
  gcnt_t gap_r;

  logic [addr_width_p-1:0] src_a [num_req_p];
  logic [addr_width_p-1:0] dst_a [num_req_p];
  logic [len_width_p-1:0] len_a [num_req_p];

  for (genvar g = 0; g < num_req_p; g++) begin : g_unpack
    assign src_a[g] = req_src_i[g*addr_width_p +: addr_width_p];
    assign dst_a[g] = req_dst_i[g*addr_width_p +: addr_width_p];
    assign len_a[g] = req_len_i[g*len_width_p +: len_width_p];
  end

  logic [num_req_p-1:0] gnt;
  id_t gnt_id;
  logic gnt_v;
  logic [id_w_lp:0] kw;
  id_t k;

  // Scan from rr upward with wrap; first valid requester wins.
  always_comb begin
    gnt = '0;
    gnt_id = '0;
    gnt_v = 1'b0;
    kw = '0;
    k = '0;
    for (int i = 0; i < num_req_p; i++) begin
      kw = {1'b0, rr_r} + (id_w_lp + 1)'(i);
      if (kw >= n_lp) kw = kw - n_lp;
      k = id_t'(kw);
      if (!gnt_v && req_v_i[k]) begin
        gnt_v = 1'b1;
        gnt[k] = 1'b1;
        gnt_id = k;
      end
    end
  end

  logic [len_width_p-1:0] sel_len;
  pcnt_t poll_inc;

  assign sel_len = len_a[gnt_id];
  assign poll_inc = (poll_r == max_polls_lp) ? poll_r : poll_r + pcnt_t'(1);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= idle_s;
      rr_r <= '0;
      id_r <= '0;
      err_r <= 1'b0;
      src_r <= '0;
      dst_r <= '0;
      len_r <= '0;
      poll_r <= '0;
      gap_r <= '0;
    end else begin
      case (state_r)
        idle_s: if (gnt_v) begin
          src_r <= src_a[gnt_id];
          dst_r <= dst_a[gnt_id];
          len_r <= sel_len;
          id_r <= gnt_id;
          rr_r <= (gnt_id == last_id_lp) ? '0 : gnt_id + id_t'(1);
          if (sel_len == '0) begin
            err_r <= 1'b0;
            state_r <= done_s;
          end else if (sel_len[3:0] != 4'd0) begin
            err_r <= 1'b1;
            state_r <= done_s;
          end else begin
            err_r <= 1'b0;
            state_r <= wr_src_s;
          end
        end
        wr_src_s: if (csr_yumi_i) state_r <= wr_dst_s;
        wr_dst_s: if (csr_yumi_i) state_r <= wr_len_s;
        wr_len_s: if (csr_yumi_i) state_r <= wr_ctrl_s;
        wr_ctrl_s: if (csr_yumi_i) begin
          poll_r <= '0;
          state_r <= rd_stat_s;
        end
        rd_stat_s: if (csr_yumi_i) state_r <= wait_stat_s;
        wait_stat_s: if (csr_v_i) begin
          poll_r <= poll_inc;
          if (csr_data_i[1]) begin
            err_r <= 1'b1;
            state_r <= done_s;
          end else if (!csr_data_i[0]) begin
            err_r <= 1'b0;
            state_r <= done_s;
          end else if (poll_inc == max_polls_lp) begin
            err_r <= 1'b1;
            state_r <= done_s;
          end else begin
            gap_r <= '0;
            state_r <= gap_s;
          end
        end
        gap_s: begin
          if (gap_r == gap_last_lp) state_r <= rd_stat_s;
          else gap_r <= gap_r + gcnt_t'(1);
        end
        done_s: if (done_ready_and_i) state_r <= idle_s;
        default: state_r <= idle_s;
      endcase
    end
  end

  always_comb begin
    csr_v_o = 1'b0;
    csr_w_o = 1'b0;
    csr_addr_o = '0;
    csr_data_o = '0;
    case (state_r)
      wr_src_s: begin
        csr_v_o = 1'b1;
        csr_w_o = 1'b1;
        csr_addr_o = csr_base_p + off_src_lp;
        csr_data_o = 64'(src_r);
      end
      wr_dst_s: begin
        csr_v_o = 1'b1;
        csr_w_o = 1'b1;
        csr_addr_o = csr_base_p + off_dst_lp;
        csr_data_o = 64'(dst_r);
      end
      wr_len_s: begin
        csr_v_o = 1'b1;
        csr_w_o = 1'b1;
        csr_addr_o = csr_base_p + off_len_lp;
        csr_data_o = 64'(len_r);
      end
      wr_ctrl_s: begin
        csr_v_o = 1'b1;
        csr_w_o = 1'b1;
        csr_addr_o = csr_base_p + off_ctrl_lp;
        csr_data_o = 64'd1;
      end
      rd_stat_s: begin
        csr_v_o = 1'b1;
        csr_addr_o = csr_base_p + off_stat_lp;
      end
      default: ;
    endcase
  end

  assign req_ready_and_o = (state_r == idle_s) ? gnt : '0;
  assign busy_o = (state_r != idle_s);
  assign done_v_o = (state_r == done_s);
  assign done_id_o = done_v_o ? id_r : '0;
  assign done_err_o = done_v_o & err_r;

  logic unused_stat;
  assign unused_stat = ^csr_data_i[63:2];

endmodule
